// File: rtl/pulse_gen_sequencer.sv
// pulse_gen_sequencer: Avalon-MM master that replays a CSR programme into the test pulse generator once per shot, sweeping stop delays by STEP
module pulse_gen_sequencer #(
  parameter int NUM_STOP = 5,
  parameter int SHOT_W = 16,
  parameter int GAP_W = 24
) (
  input  logic        avmm_clk,
  input  logic        avmm_reset_n,
  input  logic        s_cs,
  input  logic [3:0]  s_addr,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic        m_cs,
  output logic [2:0]  m_addr,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WR, SPACE, WAIT} state_t;
  localparam logic [2:0] LAST = 3'(NUM_STOP + 1);
  state_t state, state_n;
  logic [2:0] idx, idx_n, sel;
  logic [3:0] so;
  logic [31:0] start_cfg, wdata, rdata;
  logic [31:0] stop_base [NUM_STOP];
  logic [15:0] step, acc;
  logic [SHOT_W-1:0] nshots, shots;
  logic [GAP_W-1:0] gap, cnt;
  logic done, aborted, wr_en, go, abort, start, abt, ctl_wr, leave, fin, zero_go, stop_hit;
  assign wr_en = s_cs & s_write;
  assign go = wr_en & (s_addr == 4'd0) & s_writedata[0];
  assign abort = wr_en & (s_addr == 4'd0) & s_writedata[1];
  assign busy = state != IDLE;
  assign abt = abort & busy;
  assign start = go & ~abort & ~busy & (nshots != '0);
  assign zero_go = go & ~abort & ~busy & (nshots == '0);
  assign ctl_wr = (state == WR) & (idx == LAST);
  assign leave = ((state == SPACE) & (idx == LAST) & (gap == '0)) | ((state == WAIT) & (cnt == GAP_W'(1)));
  assign fin = leave & (shots == nshots) & ~abt;
  assign so = s_addr - 4'd3;
  assign stop_hit = (s_addr >= 4'd3) && (s_addr < 4'(3 + NUM_STOP));
  assign sel = idx_n - 3'd1;
  assign wdata = idx_n == 3'd0 ? start_cfg : idx_n == LAST ? 32'h1 : {stop_base[sel][31:16], stop_base[sel][15:0] + acc};
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: if (start) begin
        state_n = WR;
        idx_n = 3'd0;
      end
      WR: state_n = SPACE;
      SPACE: if (idx != LAST) begin
        state_n = WR;
        idx_n = idx + 3'd1;
      end else if (gap != '0) state_n = WAIT;
      default: ;
    endcase
    if (leave) begin
      state_n = shots == nshots ? IDLE : WR;
      idx_n = 3'd0;
    end
    if (abt) state_n = IDLE;
  end
  always_comb begin
    rdata = '0;
    case (s_addr)
      4'd1: rdata = {16'(shots), 13'd0, aborted, done, busy};
      4'd2: rdata = start_cfg;
      4'd8: rdata = {16'd0, step};
      4'd9: rdata = 32'(nshots);
      4'd10: rdata = 32'(gap);
      default: rdata = stop_hit ? stop_base[so[2:0]] : '0;
    endcase
  end
  always_ff @(posedge avmm_clk) begin
    if (!avmm_reset_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      m_cs <= 1'b0;
      m_write <= 1'b0;
      m_addr <= '0;
      m_writedata <= '0;
      acc <= '0;
      shots <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
      s_readdata <= '0;
      start_cfg <= '0;
      stop_base <= '{default: '0};
      step <= '0;
      nshots <= '0;
      gap <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= state == WAIT ? cnt - 1'b1 : gap;
      m_cs <= state_n == WR;
      m_write <= state_n == WR;
      if (state_n == WR) begin
        m_addr <= idx_n == LAST ? 3'd0 : idx_n + 3'd1;
        m_writedata <= wdata;
      end
      acc <= start ? '0 : ctl_wr ? acc + step : acc;
      shots <= start ? '0 : ctl_wr ? shots + 1'b1 : shots;
      done <= start ? 1'b0 : (zero_go | fin) ? 1'b1 : done;
      aborted <= start ? 1'b0 : abt ? 1'b1 : aborted;
      if (s_cs & s_read) s_readdata <= rdata;
      if (wr_en & ~busy) begin
        if (s_addr == 4'd2) start_cfg <= s_writedata;
        if (stop_hit) stop_base[so[2:0]] <= s_writedata;
        if (s_addr == 4'd8) step <= s_writedata[15:0];
        if (s_addr == 4'd9) nshots <= s_writedata[SHOT_W-1:0];
        if (s_addr == 4'd10) gap <= s_writedata[GAP_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_pulse_gen_sequencer.sv
// tb_pulse_gen_sequencer: directed and randomized sweeps checked against a closed-form model of the expected write schedule
module tb_pulse_gen_sequencer;
  logic avmm_clk = 0, avmm_reset_n = 0, s_cs = 0, s_write = 0, s_read = 0;
  logic [3:0] s_addr = 0;
  logic [31:0] s_writedata = 0, s_readdata, m_writedata;
  logic m_cs, m_write, busy;
  logic [2:0] m_addr;
  int total = 0, bad = 0, cyc = 0, last_wc = 0;
  typedef struct {int c; logic [2:0] a; logic [31:0] d;} wr_t;
  wr_t obs[$], exp_q[$];
  logic [31:0] start_cfg, stop_base [5];
  logic [15:0] step;
  int nshots, gap;

  pulse_gen_sequencer dut (
    .avmm_clk(avmm_clk), .avmm_reset_n(avmm_reset_n),
    .s_cs(s_cs), .s_addr(s_addr), .s_write(s_write), .s_writedata(s_writedata),
    .s_read(s_read), .s_readdata(s_readdata),
    .m_cs(m_cs), .m_addr(m_addr), .m_write(m_write), .m_writedata(m_writedata),
    .busy(busy)
  );

  always #5 avmm_clk = ~avmm_clk;
  always @(posedge avmm_clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  always @(negedge avmm_clk)
    if (m_cs === 1'b1) begin
      obs.push_back('{cyc, m_addr, m_writedata});
      chk("m_write_with_cs", m_write, 1);
    end

  task automatic wr(int a, logic [31:0] d);
    @(negedge avmm_clk);
    s_cs = 1; s_write = 1; s_addr = a[3:0]; s_writedata = d;
    last_wc = cyc;
    @(negedge avmm_clk);
    s_cs = 0; s_write = 0;
  endtask

  task automatic rd(int a, output logic [31:0] d);
    @(negedge avmm_clk);
    s_cs = 1; s_read = 1; s_addr = a[3:0];
    @(negedge avmm_clk);
    s_cs = 0; s_read = 0;
    d = s_readdata;
  endtask

  task automatic program_regs();
    wr(2, start_cfg);
    for (int i = 0; i < 5; i++) wr(3 + i, stop_base[i]);
    wr(8, {16'd0, step});
    wr(9, nshots);
    wr(10, gap);
  endtask

  // Expected schedule: shot k starts at t0 + k*(14+gap), writes every 2 cycles, stop delay offset k*step mod 2^16
  task automatic go_model();
    int t0;
    obs.delete();
    exp_q.delete();
    wr(0, 1);
    t0 = last_wc + 1;
    for (int k = 0; k < nshots; k++)
      for (int j = 0; j < 7; j++) begin
        logic [31:0] d;
        logic [15:0] off;
        off = 16'(k * step);
        d = j == 0 ? start_cfg : j == 6 ? 32'h1 : {stop_base[j-1][31:16], stop_base[j-1][15:0] + off};
        exp_q.push_back('{t0 + k * (14 + gap) + 2 * j, j == 6 ? 3'd0 : 3'(j + 1), d});
      end
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge avmm_clk);
      n++;
    end
    chk({tag, "_idle_in_budget"}, n < budget, 1);
  endtask

  task automatic compare(string tag);
    chk({tag, "_nwrites"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      chk({tag, "_cycle"}, obs[i].c, exp_q[i].c);
      chk({tag, "_addr"}, obs[i].a, exp_q[i].a);
      chk({tag, "_data"}, obs[i].d, exp_q[i].d);
    end
  endtask

  task automatic run(string tag);
    logic [31:0] st;
    go_model();
    wait_idle(tag, nshots * (14 + gap) + 40);
    repeat (3) @(negedge avmm_clk);
    compare(tag);
    rd(1, st);
    chk({tag, "_status"}, st, {16'(nshots), 16'h0002});
  endtask

  task automatic basic_cfg();
    start_cfg = 32'h800A000A;
    stop_base = '{32'h800A0014, 32'h800A0032, 32'h800A0064, 32'h800A00C8, 32'h800A01F4};
    step = 0; nshots = 1; gap = 0;
  endtask

  task automatic wait_writes(int n, int budget);
    int c = 0;
    while (obs.size() < n && c < budget) begin
      @(negedge avmm_clk);
      c++;
    end
    chk("writes_in_budget", c < budget, 1);
  endtask

  initial begin
    logic [31:0] st;
    repeat (3) @(negedge avmm_clk);
    chk("rst_m_cs", m_cs, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", s_readdata, 0);
    avmm_reset_n = 1;
    rd(1, st); chk("rst_status", st, 0);
    rd(8, st); chk("rst_step", st, 0);

    basic_cfg();
    program_regs();
    rd(2, st); chk("rb_start", st, start_cfg);
    rd(7, st); chk("rb_stop4", st, stop_base[4]);
    rd(0, st); chk("rb_ctrl", st, 0);
    rd(12, st); chk("rb_unmapped", st, 0);
    run("basic");

    nshots = 3; step = 5; gap = 10;
    program_regs();
    run("sweep");

    stop_base[0] = 32'h8000FFFE; step = 3; nshots = 2; gap = 0;
    program_regs();
    run("wrap");
    chk("wrap_stop0", obs.size() > 8 ? obs[8].d : 32'hx, 32'h80000001);

    for (int r = 0; r < 3; r++) begin
      start_cfg = $urandom;
      for (int i = 0; i < 5; i++) stop_base[i] = $urandom;
      step = 16'($urandom);
      nshots = $urandom_range(1, 4);
      gap = $urandom_range(0, 20);
      program_regs();
      run("rand");
    end

    basic_cfg();
    nshots = 100; gap = 1000; step = 1;
    program_regs();
    go_model();
    wait_writes(14, 2200);
    wr(0, 2);
    repeat (40) @(negedge avmm_clk);
    chk("abort_nwrites", obs.size(), 14);
    chk("abort_busy", busy, 0);
    rd(1, st); chk("abort_status", st, 32'h00020004);

    nshots = 0;
    wr(9, 0);
    obs.delete();
    wr(0, 1);
    repeat (10) @(negedge avmm_clk);
    chk("zero_nwrites", obs.size(), 0);
    rd(1, st); chk("zero_done_busy", st[1:0], 2'b10);

    wr(9, 1);
    obs.delete();
    wr(0, 3);
    repeat (20) @(negedge avmm_clk);
    chk("goabort_nwrites", obs.size(), 0);
    chk("goabort_busy", busy, 0);

    basic_cfg();
    step = 7; nshots = 2; gap = 5;
    program_regs();
    go_model();
    repeat (3) @(negedge avmm_clk);
    wr(8, 99);
    wr(0, 1);
    rd(8, st); chk("busy_step_kept", st, 7);
    wait_idle("gobusy", 100);
    repeat (3) @(negedge avmm_clk);
    compare("gobusy");
    rd(1, st); chk("gobusy_status", st, 32'h00020002);

    basic_cfg();
    nshots = 3; gap = 50;
    program_regs();
    go_model();
    wait_writes(7, 100);
    repeat (5) @(negedge avmm_clk);
    avmm_reset_n = 0;
    @(negedge avmm_clk);
    avmm_reset_n = 1;
    chk("midrst_m_cs", m_cs, 0);
    chk("midrst_busy", busy, 0);
    for (int a = 0; a < 11; a++) begin
      rd(a, st);
      chk("midrst_csr", st, 0);
    end
    repeat (60) @(negedge avmm_clk);
    chk("midrst_nwrites", obs.size(), 7);
    basic_cfg();
    program_regs();
    run("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
